// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath control strobe, plus a retired-instruction counter.
module mips_control_fsm #(
  parameter int RESET_TO_FETCH = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             mem_rd_ena,
  output logic             mem_wr_ena,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // Only FETCH is a valid post-reset state; reject any other setting at elaboration.
  if (RESET_TO_FETCH != 1) begin : g_bad_reset_state
    $error("mips_control_fsm: RESET_TO_FETCH must be 1");
  end

  state_t           state_q;
  state_t           decode_next;
  logic             is_store_q;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  always_comb begin
    decode_next = FETCH;
    case (opcode)
      OP_RTYPE:                         decode_next = EXECUTE;
      OP_LW, OP_SW:                     decode_next = MEM_ADDR;
      OP_BEQ:                           decode_next = BRANCH;
      OP_J:                             decode_next = JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_next = IMM_EXEC;
      default:                          decode_next = FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      MEM_WB, ALU_WB, IMM_WB, BRANCH, JUMP: retire = 1'b1;
      MEM_WRITE:                            retire = mem_ready;
      default:                              retire = 1'b0;
    endcase
  end

  // lw/sw choice is captured in DECODE so MEM_ADDR does not re-read opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      is_store_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        FETCH:     if (mem_ready) state_q <= DECODE;
        DECODE: begin
          state_q    <= decode_next;
          is_store_q <= (opcode == OP_SW);
        end
        MEM_ADDR:  state_q <= is_store_q ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (mem_ready) state_q <= MEM_WB;
        MEM_WRITE: if (mem_ready) state_q <= FETCH;
        EXECUTE:   state_q <= ALU_WB;
        IMM_EXEC:  state_q <= IMM_WB;
        default:   state_q <= FETCH;
      endcase
    end
  end

  // Moore decode; reset forces the PC-load-only pattern and masks all strobes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    mem_rd_ena  = 1'b0;
    mem_wr_ena  = 1'b0;
    illegal_op  = 1'b0;
    if (rst) begin
      PCWrite = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          mem_rd_ena = 1'b1;
          ALUSrcB    = 2'b01;
          IRWrite    = mem_ready;
          PCWrite    = mem_ready;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = (decode_next == FETCH);
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_READ: begin
          IorD       = 1'b1;
          mem_rd_ena = 1'b1;
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
        end
        MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEM_WRITE: begin
          IorD       = 1'b1;
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          mem_wr_ena = mem_ready;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        ALU_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        IMM_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (opcode)
            OP_ANDI: ALUOp = 3'b011;
            OP_ORI:  ALUOp = 3'b100;
            OP_SLTI: ALUOp = 3'b101;
            default: ALUOp = 3'b000;
          endcase
        end
        IMM_WB:  RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: one step per clock, checking state,
// packed control bus and retired counters against hand-computed values.
module tb_mips_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        mem_rd_ena, mem_wr_ena, illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  // Narrow-counter twin sharing the same stimulus; used to observe wrap-around.
  logic        s_pcw, s_pcwc, s_iord, s_m2r, s_irw, s_rdst, s_rw, s_asa;
  logic [1:0]  s_asb, s_pcs;
  logic [2:0]  s_aop;
  logic        s_rd, s_wr, s_ill;
  logic [3:0]  s_state;
  logic [2:0]  s_retired;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  mips_control_fsm #(.RESET_TO_FETCH(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .mem_rd_ena(mem_rd_ena),
    .mem_wr_ena(mem_wr_ena), .illegal_op(illegal_op), .state(state),
    .instr_retired(instr_retired)
  );

  mips_control_fsm #(.RESET_TO_FETCH(1), .CNT_W(3)) dut_narrow (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(s_pcw), .PCWriteCond(s_pcwc), .IorD(s_iord), .MemtoReg(s_m2r),
    .IRWrite(s_irw), .RegDst(s_rdst), .RegWrite(s_rw), .ALUSrcA(s_asa),
    .ALUSrcB(s_asb), .ALUOp(s_aop), .PCSource(s_pcs), .mem_rd_ena(s_rd),
    .mem_wr_ena(s_wr), .illegal_op(s_ill), .state(s_state),
    .instr_retired(s_retired)
  );

  // Bus order: PCWrite PCWriteCond IorD MemtoReg IRWrite RegDst RegWrite ALUSrcA
  //            ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0] mem_rd mem_wr illegal
  function automatic logic [18:0] ctl(input logic pcw, pcwc, iord, m2r, irw, rdst, rw, asa,
                                      input logic [1:0] asb, input logic [2:0] aop,
                                      input logic [1:0] pcs, input logic rd, wr, ill);
    return {pcw, pcwc, iord, m2r, irw, rdst, rw, asa, asb, aop, pcs, rd, wr, ill};
  endfunction

  logic [18:0] ctl_obs;
  assign ctl_obs = {PCWrite, PCWriteCond, IorD, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
                    ALUSrcB, ALUOp, PCSource, mem_rd_ena, mem_wr_ena, illegal_op};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step%0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
    end
  endtask

  // Drive inputs just after the edge, let decode settle, then check this cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] exp_state, input logic [18:0] exp_ctl,
                      input logic [31:0] exp_cnt);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = mr;
    #1;
    step_no++;
    chk("state", {28'd0, state}, {28'd0, exp_state});
    chk("ctl", {13'd0, ctl_obs}, {13'd0, exp_ctl});
    chk("retired", instr_retired, exp_cnt);
    chk("retired_narrow", {29'd0, s_retired}, {29'd0, exp_cnt[2:0]});
  endtask

  initial begin
    logic [18:0] c_rst, c_fwait, c_fgo, c_dec, c_dec_ill, c_exe, c_alu_wb, c_maddr;
    logic [18:0] c_mrd, c_mwb, c_mwr_wait, c_mwr_go, c_br, c_j, c_ori, c_slti, c_andi, c_imm_wb;
    //               pcw  pcwc iord m2r  irw  rdst rw   asa  asb    aop     pcs    rd   wr   ill
    c_rst      = ctl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0);
    c_fwait    = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b1,1'b0,1'b0);
    c_fgo      = ctl(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b1,1'b0,1'b0);
    c_dec      = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b0,1'b0,1'b0);
    c_dec_ill  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b0,1'b0,1'b1);
    c_exe      = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,2'b00,1'b0,1'b0,1'b0);
    c_alu_wb   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0);
    c_maddr    = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0,1'b0);
    c_mrd      = ctl(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b1,1'b0,1'b0);
    c_mwb      = ctl(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0);
    c_mwr_wait = ctl(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0,1'b0);
    c_mwr_go   = ctl(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b1,1'b0);
    c_br       = ctl(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b01,1'b0,1'b0,1'b0);
    c_j        = ctl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b0,1'b0,1'b0);
    c_ori      = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b100,2'b00,1'b0,1'b0,1'b0);
    c_slti     = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b101,2'b00,1'b0,1'b0,1'b0);
    c_andi     = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b011,2'b00,1'b0,1'b0,1'b0);
    c_imm_wb   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0);

    rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;

    // Reset held two cycles, then release into FETCH waiting on memory.
    step(1'b1, 6'b000000, 1'b0, 4'd0, c_rst, 0);
    step(1'b1, 6'b000000, 1'b0, 4'd0, c_rst, 0);
    step(1'b0, 6'b000000, 1'b0, 4'd0, c_fwait, 0);

    // R-type: 0,1,6,7,0
    step(1'b0, 6'b000000, 1'b1, 4'd0, c_fgo, 0);
    step(1'b0, 6'b000000, 1'b1, 4'd1, c_dec, 0);
    step(1'b0, 6'b000000, 1'b1, 4'd6, c_exe, 0);
    step(1'b0, 6'b000000, 1'b1, 4'd7, c_alu_wb, 0);

    // lw with three wait cycles in MEM_READ: 0,1,2,3,3,3,3,4,0
    step(1'b0, 6'b100011, 1'b1, 4'd0, c_fgo, 1);
    step(1'b0, 6'b100011, 1'b1, 4'd1, c_dec, 1);
    step(1'b0, 6'b100011, 1'b1, 4'd2, c_maddr, 1);
    step(1'b0, 6'b100011, 1'b0, 4'd3, c_mrd, 1);
    step(1'b0, 6'b100011, 1'b0, 4'd3, c_mrd, 1);
    step(1'b0, 6'b100011, 1'b0, 4'd3, c_mrd, 1);
    step(1'b0, 6'b100011, 1'b1, 4'd3, c_mrd, 1);
    step(1'b0, 6'b100011, 1'b1, 4'd4, c_mwb, 1);

    // sw with one wait cycle: write strobe only on the ready cycle
    step(1'b0, 6'b101011, 1'b1, 4'd0, c_fgo, 2);
    step(1'b0, 6'b101011, 1'b1, 4'd1, c_dec, 2);
    step(1'b0, 6'b101011, 1'b1, 4'd2, c_maddr, 2);
    step(1'b0, 6'b101011, 1'b0, 4'd5, c_mwr_wait, 2);
    step(1'b0, 6'b101011, 1'b1, 4'd5, c_mwr_go, 2);

    // beq then j back to back, 6 cycles
    step(1'b0, 6'b000100, 1'b1, 4'd0, c_fgo, 3);
    step(1'b0, 6'b000100, 1'b1, 4'd1, c_dec, 3);
    step(1'b0, 6'b000100, 1'b1, 4'd8, c_br, 3);
    step(1'b0, 6'b000010, 1'b1, 4'd0, c_fgo, 4);
    step(1'b0, 6'b000010, 1'b1, 4'd1, c_dec, 4);
    step(1'b0, 6'b000010, 1'b1, 4'd9, c_j, 4);

    // Illegal opcode: illegal_op pulse in DECODE, back to FETCH, no retire
    step(1'b0, 6'b111111, 1'b1, 4'd0, c_fgo, 5);
    step(1'b0, 6'b111111, 1'b1, 4'd1, c_dec_ill, 5);

    // ori, slti, andi: the narrow counter goes 5,6,7 then wraps to 0
    step(1'b0, 6'b001101, 1'b1, 4'd0, c_fgo, 5);
    step(1'b0, 6'b001101, 1'b1, 4'd1, c_dec, 5);
    step(1'b0, 6'b001101, 1'b1, 4'd10, c_ori, 5);
    step(1'b0, 6'b001101, 1'b1, 4'd11, c_imm_wb, 5);
    step(1'b0, 6'b001010, 1'b1, 4'd0, c_fgo, 6);
    step(1'b0, 6'b001010, 1'b1, 4'd1, c_dec, 6);
    step(1'b0, 6'b001010, 1'b1, 4'd10, c_slti, 6);
    step(1'b0, 6'b001010, 1'b1, 4'd11, c_imm_wb, 6);
    step(1'b0, 6'b001100, 1'b1, 4'd0, c_fgo, 7);
    step(1'b0, 6'b001100, 1'b1, 4'd1, c_dec, 7);
    step(1'b0, 6'b001100, 1'b1, 4'd10, c_andi, 7);
    step(1'b0, 6'b001100, 1'b1, 4'd11, c_imm_wb, 7);

    // sw interrupted by reset mid-wait with mem_ready=1: no write strobe, no retire
    step(1'b0, 6'b101011, 1'b1, 4'd0, c_fgo, 8);
    step(1'b0, 6'b101011, 1'b1, 4'd1, c_dec, 8);
    step(1'b0, 6'b101011, 1'b1, 4'd2, c_maddr, 8);
    step(1'b0, 6'b101011, 1'b0, 4'd5, c_mwr_wait, 8);
    step(1'b1, 6'b101011, 1'b1, 4'd5, c_rst, 8);
    step(1'b0, 6'b101011, 1'b0, 4'd0, c_fwait, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_control_fsm.md
Name: mips_control_fsm

Overview:
Multicycle MIPS control unit that sequences the multicycle datapath. It decodes the latched instruction opcode, walks one FSM path per instruction class, and drives every datapath control strobe. It also handles the memory ready handshake and counts retired instructions. It sits beside the datapath in the CPU top, and its outputs connect 1:1 to the datapath control inputs.

Parameters:
RESET_TO_FETCH, 1, state entered when rst releases (1 = FETCH; 0 reserved, must remain 1)
CNT_W, 32, width of instr_retired counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from IR
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0 = mem addr from PC; 1 = from ALUout
MemtoReg  out  1  1 = regfile write data from MDR
IRWrite  out  1  latch instruction
RegDst  out  1  1 = rd; 0 = rt
RegWrite  out  1  regfile write enable
ALUSrcA  out  1  0 = PC; 1 = A
ALUSrcB  out  2  00 = B; 01 = 4; 10 = sign-ext imm; 11 = imm<<2
ALUOp  out  3  000 add, 001 sub, 010 R-type funct, 011 and, 100 or, 101 slt
PCSource  out  2  00 = ALU result; 01 = ALUout; 10 = jump target
mem_rd_ena  out  1  memory read request
mem_wr_ena  out  1  memory write strobe
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state  out  4  current state (debug)
instr_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst is synchronous and active-high. While rst=1: state<=FETCH, instr_retired<=0. All outputs are 0 except PCWrite=1, so the datapath loads its reset vector 0x00400000.
- Outputs are Moore, decoded combinationally from state. The only exceptions are the mem_ready-gated strobes noted below. Any control not listed for a state is 0.
- States (encodings 0-11):
  - FETCH(0): IorD=0, mem_rd_ena=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite assert only when mem_ready=1. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=000, which places the branch target in ALUout. Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000, 001100, 001101, 001010 -> IMM_EXEC
    - any other opcode -> FETCH, with illegal_op=1 for this cycle.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): IorD=1, mem_rd_ena=1. Holds the MEM_ADDR ALU controls, because ALUout is always enabled and must keep the address. Stays while mem_ready=0; goes to MEM_WB on mem_ready=1 (MDR captures data on that edge).
  - MEM_WB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
  - MEM_WRITE(5): IorD=1, holds the MEM_ADDR ALU controls. mem_wr_ena=1 only while mem_ready=1. Stays while mem_ready=0; goes to FETCH on mem_ready=1.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next ALU_WB.
  - ALU_WB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Next FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Next FETCH.
  - IMM_EXEC(10): ALUSrcA=1, ALUSrcB=10. ALUOp is 000 for addi, 011 for andi, 100 for ori, 101 for slti. Next IMM_WB.
  - IMM_WB(11): RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
  - Encodings 12-15 -> FETCH next cycle; all outputs 0.
- Latency with mem_ready tied 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, I-type 4. Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- instr_retired increments by 1 on the final state of each legal instruction: MEM_WB, ALU_WB, IMM_WB, BRANCH, JUMP, and MEM_WRITE when mem_ready=1. Illegal opcodes do not count. Wraps from 2^CNT_W-1 to 0.
- opcode is sampled only in DECODE and IMM_EXEC; it is stable there because IRWrite=0.
- rst asserted in any state, including mid-wait, wins: the next state is FETCH and no write strobe is issued in the reset cycle.

Test Plan:
1. rst=1 for 2 cycles -> PCWrite=1, every other output 0, state=0, instr_retired=0. Release -> FETCH, mem_rd_ena=1.
2. mem_ready=1, opcode 000000 -> state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instr_retired=1.
3. opcode 100011, mem_ready low for 3 cycles in MEM_READ -> sequence 0,1,2,3,3,3,3,4,0. IorD=1 throughout state 3; RegWrite=1 and MemtoReg=1 in state 4.
4. opcode 101011, mem_ready=0 for 1 cycle then 1 -> mem_wr_ena=0 on the wait cycle and 1 for exactly one cycle. Returns to FETCH; instr_retired increments once.
5. Back-to-back beq (000100) then j (000010) -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=001. JUMP shows PCWrite=1, PCSource=10. 6 cycles total; instr_retired=2.
6. opcode 111111 -> DECODE pulses illegal_op=1 for 1 cycle, next state FETCH, instr_retired unchanged. Separately, preload instr_retired to 0xFFFFFFFF and retire one instruction -> counter wraps to 0.
